fbrc_counter_gen: RTL and testbench

Parametrised successor to the team's fixed 4-bit prescaled LED counter. Provides a WIDTH-bit modulo-MODULUS up/down counter with these features:
- built-in prescaler tick
- synchronous parallel load
- run/pause
- wrap (terminal-count) pulse

Drives board LEDs or feeds downstream display logic. One instance per channel.

---
 rtl/fbrc_pkg.sv | 17 +
 rtl/fbrc_prescaler.sv | 41 ++++
 rtl/fbrc_counter_gen.sv | 104 ++++++++++
 tb/tb_fbrc_counter_gen.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbrc_pkg.sv
// Shared types, board constants and helpers for the prescaled channel counter.
package fbrc_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_t;

    localparam int BOARD_CLK_HZ     = 50000000;
    localparam int DEFAULT_PRESCALE = BOARD_CLK_HZ / 2;

    // A one-cycle prescaler still needs a 1-bit register to stay legal.
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fbrc_prescaler.sv
// Step generator: one-cycle step every PRESCALE run-cycles, restartable by clr.
module fbrc_prescaler
    import fbrc_pkg::*;
#(
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clr,
    output logic step
);

    localparam int            PW     = clog2_min1(PRESCALE);
    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] p_q;
    logic [PW-1:0] p_d;

    assign step = run & (p_q == P_LAST);

    always_comb begin
        p_d = p_q;
        if (clr) begin
            p_d = '0;
        end else if (step) begin
            p_d = '0;
        end else if (run) begin
            p_d = p_q + PW'(1);
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

endmodule

// File: rtl/fbrc_counter_gen.sv
// Modulo-MODULUS up/down channel counter with prescaler, load, and tick/tc pulses.
// Define FBRC_GRAY_OUT_EN to present q as the Gray code of the internal binary count.
module fbrc_counter_gen
    import fbrc_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter int PRESCALE = DEFAULT_PRESCALE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             tc
);

    if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH) || PRESCALE < 1) begin : g_bad_params
        $error("fbrc_counter_gen: illegal WIDTH/MODULUS/PRESCALE");
    end

    // Terminal value held at WIDTH bits so MODULUS=2**WIDTH never overflows the compare.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    logic             step;
    dir_t             dir;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tick_q, tick_d;
    logic             tc_q, tc_d;

    assign dir = dir_t'(up);

    fbrc_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .clr   (load),
        .step  (step)
    );

    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_VAL) ? MAX_VAL : load_val;
        end else if (step) begin
            tick_d = 1'b1;
            if (dir == DIR_UP) begin
                if (count_q == MAX_VAL) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_VAL;
                    tc_d    = 1'b1;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(negedge clk) begin
        if (reset) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            tc_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= tick_d;
            tc_q    <= tc_d;
        end
    end

    assign tick = tick_q;
    assign tc   = tc_q;

`ifdef FBRC_GRAY_OUT_EN
    // Encoded from the next binary value so the Gray output lines up with tick.
    logic [WIDTH-1:0] gray_q;

    always_ff @(negedge clk) begin
        if (reset) begin
            gray_q <= '0;
        end else begin
            gray_q <= count_d ^ (count_d >> 1);
        end
    end

    assign q = gray_q;
`else
    assign q = count_q;
`endif

endmodule

// File: tb/tb_fbrc_counter_gen.sv
// Randomized and directed bench for fbrc_counter_gen against an arithmetic reference model.
module tb_fbrc_counter_gen;

    localparam int MOD0 = 10;
    localparam int PRE0 = 4;
    localparam int MOD1 = 16;
    localparam int PRE1 = 1;

    logic       clk = 1'b0;
    logic       reset0 = 1'b1, run0 = 1'b0, up0 = 1'b1, load0 = 1'b0;
    logic [3:0] lv0 = 4'd0;
    logic [3:0] q0;
    logic       tick0, tc0;
    logic       reset1 = 1'b1, run1 = 1'b0, up1 = 1'b1, load1 = 1'b0;
    logic [3:0] lv1 = 4'd0;
    logic [3:0] q1;
    logic       tick1, tc1;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int   q;
        int   p;
        logic tick;
        logic tc;
    } mdl_t;

    mdl_t m0 = '0;
    mdl_t m1 = '0;

    always #5 clk = ~clk;

    fbrc_counter_gen #(.WIDTH(4), .MODULUS(MOD0), .PRESCALE(PRE0)) dut0 (
        .clk(clk), .reset(reset0), .run(run0), .up(up0), .load(load0),
        .load_val(lv0), .q(q0), .tick(tick0), .tc(tc0)
    );

    fbrc_counter_gen #(.WIDTH(4), .MODULUS(MOD1), .PRESCALE(PRE1)) dut1 (
        .clk(clk), .reset(reset1), .run(run1), .up(up1), .load(load1),
        .load_val(lv1), .q(q1), .tick(tick1), .tc(tc1)
    );

    function automatic mdl_t mdl_next(mdl_t s, logic rst, logic ld, int lv, logic rn,
                                      logic u, int modv, int pre);
        mdl_t n = s;
        n.tick = 1'b0;
        n.tc   = 1'b0;
        if (rst) begin
            n.q = 0;
            n.p = 0;
        end else if (ld) begin
            n.q = (lv > modv - 1) ? modv - 1 : lv;
            n.p = 0;
        end else if (rn) begin
            if (s.p + 1 == pre) begin
                n.p    = 0;
                n.tick = 1'b1;
                if (u) begin
                    n.q  = (s.q + 1) % modv;
                    n.tc = (s.q == modv - 1);
                end else begin
                    n.q  = (s.q + modv - 1) % modv;
                    n.tc = (s.q == 0);
                end
            end else begin
                n.p = s.p + 1;
            end
        end
        return n;
    endfunction

    function automatic logic [3:0] exp_out(int b);
`ifdef FBRC_GRAY_OUT_EN
        return 4'(b ^ (b >> 1));
`else
        return 4'(b);
`endif
    endfunction

    // Advance one active (falling) edge, then return at the rising edge to sample and drive.
    task automatic cycle();
        @(negedge clk);
        m0 = mdl_next(m0, reset0, load0, int'(lv0), run0, up0, MOD0, PRE0);
        m1 = mdl_next(m1, reset1, load1, int'(lv1), run1, up1, MOD1, PRE1);
        @(posedge clk);
    endtask

    task automatic do_reset0();
        reset0 = 1'b1; load0 = 1'b0; run0 = 1'b0;
        cycle();
        reset0 = 1'b0;
    endtask

    task automatic test_reset();
        reset0 = 1'b1; load0 = 1'b1; run0 = 1'b1; lv0 = 4'd7;
        reset1 = 1'b1; run1 = 1'b1;
        cycle();
        checks++;
        if (q0 !== exp_out(0) || tick0 !== 1'b0 || tc0 !== 1'b0) begin
            errors++;
            $display("FAIL reset0: q=%0d tick=%0b tc=%0b expected q=%0d tick=0 tc=0", q0, tick0, tc0, exp_out(0));
        end
        checks++;
        if (q1 !== exp_out(0) || tick1 !== 1'b0 || tc1 !== 1'b0) begin
            errors++;
            $display("FAIL reset1: q=%0d tick=%0b tc=%0b expected q=%0d tick=0 tc=0", q1, tick1, tc1, exp_out(0));
        end
        reset0 = 1'b0; load0 = 1'b0; run0 = 1'b0;
        run1 = 1'b0;
    endtask

    task automatic test_count_up();
        int nticks = 0;
        int ntc = 0;
        int tc_q = -1;
        do_reset0();
        run0 = 1'b1; up0 = 1'b1;
        for (int i = 0; i < 44; i++) begin
            cycle();
            checks++;
            if (q0 !== exp_out(m0.q) || tick0 !== m0.tick || tc0 !== m0.tc) begin
                errors++;
                $display("FAIL count_up cyc %0d: q=%0d tick=%0b tc=%0b expected q=%0d tick=%0b tc=%0b",
                         i, q0, tick0, tc0, exp_out(m0.q), m0.tick, m0.tc);
            end
            if (tick0 === 1'b1) nticks++;
            if (tc0 === 1'b1) begin ntc++; tc_q = int'(q0); end
        end
        checks++;
        if (nticks != 11 || ntc != 1 || tc_q != int'(exp_out(0)) || q0 !== exp_out(1)) begin
            errors++;
            $display("FAIL count_up_summary: ticks=%0d tc=%0d tc_q=%0d final_q=%0d expected 11 1 %0d %0d",
                     nticks, ntc, tc_q, q0, exp_out(0), exp_out(1));
        end
    endtask

    task automatic test_count_down();
        int seq[$];
        int tc_idx = -1;
        do_reset0();
        load0 = 1'b1; lv0 = 4'd2;
        cycle();
        load0 = 1'b0; up0 = 1'b0; run0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cycle();
            checks++;
            if (q0 !== exp_out(m0.q) || tick0 !== m0.tick || tc0 !== m0.tc) begin
                errors++;
                $display("FAIL count_down cyc %0d: q=%0d tick=%0b tc=%0b expected q=%0d tick=%0b tc=%0b",
                         i, q0, tick0, tc0, exp_out(m0.q), m0.tick, m0.tc);
            end
            if (tick0 === 1'b1) begin
                if (tc0 === 1'b1) tc_idx = seq.size();
                seq.push_back(int'(q0));
            end
        end
        checks++;
        if (seq.size() != 4 || seq[0] != int'(exp_out(1)) || seq[1] != int'(exp_out(0)) ||
            seq[2] != int'(exp_out(9)) || seq[3] != int'(exp_out(8)) || tc_idx != 2) begin
            errors++;
            $display("FAIL count_down_seq: n=%0d tc_idx=%0d expected 4 steps 1,0,9,8 with tc at index 2",
                     seq.size(), tc_idx);
        end
        up0 = 1'b1;
    endtask

    task automatic test_load_clamp();
        do_reset0();
        run0 = 1'b1; up0 = 1'b1;
        cycle();
        cycle();
        load0 = 1'b1; lv0 = 4'd13;
        cycle();
        load0 = 1'b0;
        checks++;
        if (q0 !== exp_out(9) || tick0 !== 1'b0 || tc0 !== 1'b0) begin
            errors++;
            $display("FAIL load_clamp: q=%0d tick=%0b expected q=%0d tick=0", q0, tick0, exp_out(9));
        end
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (q0 !== exp_out(9) || tick0 !== 1'b0) begin
                errors++;
                $display("FAIL load_latency cyc %0d: q=%0d tick=%0b expected q=%0d tick=0", i, q0, tick0, exp_out(9));
            end
        end
        cycle();
        checks++;
        if (q0 !== exp_out(0) || tick0 !== 1'b1 || tc0 !== 1'b1) begin
            errors++;
            $display("FAIL load_wrap: q=%0d tick=%0b tc=%0b expected q=%0d tick=1 tc=1", q0, tick0, tc0, exp_out(0));
        end
    endtask

    task automatic test_pause_reset();
        do_reset0();
        load0 = 1'b1; lv0 = 4'd7;
        cycle();
        load0 = 1'b0; run0 = 1'b1; up0 = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        run0 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (q0 !== exp_out(7) || tick0 !== 1'b0 || tc0 !== 1'b0) begin
                errors++;
                $display("FAIL pause cyc %0d: q=%0d tick=%0b expected q=%0d tick=0", i, q0, tick0, exp_out(7));
            end
        end
        reset0 = 1'b1; load0 = 1'b1; lv0 = 4'd5; run0 = 1'b1;
        cycle();
        checks++;
        if (q0 !== exp_out(0) || tick0 !== 1'b0 || tc0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_dominates: q=%0d tick=%0b tc=%0b expected q=%0d tick=0 tc=0", q0, tick0, tc0, exp_out(0));
        end
        reset0 = 1'b0; load0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (q0 !== exp_out(m0.q) || tick0 !== m0.tick || tc0 !== m0.tc) begin
                errors++;
                $display("FAIL resume cyc %0d: q=%0d tick=%0b expected q=%0d tick=%0b", i, q0, tick0, exp_out(m0.q), m0.tick);
            end
        end
    endtask

    task automatic test_random();
        do_reset0();
        for (int i = 0; i < 600; i++) begin
            reset0 = ($urandom_range(0, 49) == 0);
            load0  = ($urandom_range(0, 11) == 0);
            run0   = ($urandom_range(0, 3) != 0);
            up0    = 1'($urandom_range(0, 1));
            lv0    = 4'($urandom_range(0, 15));
            cycle();
            checks++;
            if (q0 !== exp_out(m0.q) || tick0 !== m0.tick || tc0 !== m0.tc) begin
                errors++;
                $display("FAIL random cyc %0d: q=%0d tick=%0b tc=%0b expected q=%0d tick=%0b tc=%0b",
                         i, q0, tick0, tc0, exp_out(m0.q), m0.tick, m0.tc);
            end
        end
        reset0 = 1'b0; load0 = 1'b0;
    endtask

    task automatic test_prescale1();
        int ntc = 0;
        logic [3:0] prev;
        reset1 = 1'b1;
        cycle();
        reset1 = 1'b0; run1 = 1'b1; up1 = 1'b1;
        prev = q1;
        for (int i = 0; i < 40; i++) begin
            cycle();
            checks++;
            if (q1 !== exp_out(m1.q) || tick1 !== 1'b1 || tc1 !== m1.tc) begin
                errors++;
                $display("FAIL prescale1 cyc %0d: q=%0d tick=%0b tc=%0b expected q=%0d tick=1 tc=%0b",
                         i, q1, tick1, tc1, exp_out(m1.q), m1.tc);
            end
`ifdef FBRC_GRAY_OUT_EN
            checks++;
            if ($countones(q1 ^ prev) != 1) begin
                errors++;
                $display("FAIL gray_step cyc %0d: prev=%b q=%b expected one-bit change", i, prev, q1);
            end
`endif
            if (tc1 === 1'b1) ntc++;
            prev = q1;
        end
        checks++;
        if (ntc != 2 || q1 !== exp_out(8)) begin
            errors++;
            $display("FAIL prescale1_summary: tc=%0d q=%0d expected tc=2 q=%0d", ntc, q1, exp_out(8));
        end
        run1 = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        test_reset();
        test_count_up();
        test_count_down();
        test_load_clamp();
        test_pause_reset();
        test_random();
        test_prescale1();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
